xbar_id_tracker: RTL and testbench

- Per-master transaction-ordering and write-routing tracker for the crossbar master-side port. It is the successor to the single-bit-per-ID blocking scheme.
- Each ID may have up to MAX_OUTSTANDING transactions in flight, provided they all target the same slave; AXI same-ID ordering is preserved without stalling on every repeat ID.
- A depth-WQ_DEPTH queue of AW destinations lets several write addresses be issued ahead of their W data.
- W beats are steered in AW order.

---
 rtl/xbar_id_tracker_if.sv | 49 ++++
 rtl/xbar_id_tracker.sv | 153 +++++++++++++++
 tb/tb_xbar_id_tracker.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xbar_id_tracker_if.sv
// Master-side crossbar tracker bus: AR/AW issue handshakes, R/B completions and W routing.
interface xbar_id_tracker_if #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEST_WIDTH = 1
);
  logic                  ar_valid;
  logic [ID_WIDTH-1:0]   ar_id;
  logic [DEST_WIDTH-1:0] ar_dest;
  logic                  ar_ready;
  logic                  ar_issue;

  logic                  aw_valid;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [DEST_WIDTH-1:0] aw_dest;
  logic                  aw_ready;
  logic                  aw_issue;

  logic                  r_done;
  logic [ID_WIDTH-1:0]   r_done_id;
  logic                  b_done;
  logic [ID_WIDTH-1:0]   b_done_id;

  logic                  w_valid;
  logic                  w_last;
  logic                  w_ready;
  logic                  w_pop;
  logic [DEST_WIDTH-1:0] w_dest;
  logic                  w_route_valid;

  logic                  err;

  // Tracker side
  modport slave (
    input  ar_valid, ar_id, ar_dest, ar_ready,
    input  aw_valid, aw_id, aw_dest, aw_ready,
    input  r_done, r_done_id, b_done, b_done_id,
    input  w_valid, w_last, w_ready,
    output ar_issue, aw_issue, w_pop, w_dest, w_route_valid, err
  );

  // Request / FIFO side
  modport master (
    output ar_valid, ar_id, ar_dest, ar_ready,
    output aw_valid, aw_id, aw_dest, aw_ready,
    output r_done, r_done_id, b_done, b_done_id,
    output w_valid, w_last, w_ready,
    input  ar_issue, aw_issue, w_pop, w_dest, w_route_valid, err
  );
endinterface

// File: rtl/xbar_id_tracker.sv
// Per-ID outstanding-transaction tracker with same-destination pipelining,
// plus an AW-destination queue that steers W beats in AW order.
module xbar_id_tracker #(
  parameter int unsigned ID_WIDTH        = 4,
  parameter int unsigned slaves          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned WQ_DEPTH        = 4
) (
  input  logic           ACLK,
  input  logic           ARESETn,
  xbar_id_tracker_if.slave bus
);

  localparam int unsigned DEST_W = (slaves > 1) ? $clog2(slaves) : 1;
  localparam int unsigned N_ID   = 1 << ID_WIDTH;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned IDX_W  = $clog2(WQ_DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [CNT_W-1:0]  ar_cnt [N_ID];
  logic [DEST_W-1:0] ar_tbl [N_ID];
  logic [CNT_W-1:0]  aw_cnt [N_ID];
  logic [DEST_W-1:0] aw_tbl [N_ID];

  logic [DEST_W-1:0] wq_mem [WQ_DEPTH];
  logic [PTR_W-1:0]  wq_wr;
  logic [PTR_W-1:0]  wq_rd;
  logic              err_q;

  logic [CNT_W-1:0]  ar_cnt_sel;
  logic [CNT_W-1:0]  aw_cnt_sel;
  logic              ar_allow;
  logic              aw_allow;
  logic              ar_go;
  logic              aw_go;
  logic              ar_done_ok;
  logic              ar_done_bad;
  logic              aw_done_ok;
  logic              aw_done_bad;
  logic              wq_empty;
  logic              wq_full;
  logic              wq_push;
  logic              wq_pop;
  logic              w_go;

  // A repeat ID may proceed only toward the slave it already has traffic with.
  assign ar_cnt_sel = ar_cnt[bus.ar_id];
  assign aw_cnt_sel = aw_cnt[bus.aw_id];
  assign ar_allow   = (ar_cnt_sel == '0) |
                      ((ar_tbl[bus.ar_id] == bus.ar_dest) & (ar_cnt_sel < CNT_MAX));
  assign aw_allow   = (aw_cnt_sel == '0) |
                      ((aw_tbl[bus.aw_id] == bus.aw_dest) & (aw_cnt_sel < CNT_MAX));

  assign ar_go = ARESETn & bus.ar_valid & bus.ar_ready & ar_allow;
  assign aw_go = ARESETn & bus.aw_valid & bus.aw_ready & aw_allow & ~wq_full;

  // Completions against an idle ID are flagged and otherwise ignored.
  assign ar_done_bad = bus.r_done & (ar_cnt[bus.r_done_id] == '0);
  assign ar_done_ok  = bus.r_done & ~ar_done_bad;
  assign aw_done_bad = bus.b_done & (aw_cnt[bus.b_done_id] == '0);
  assign aw_done_ok  = bus.b_done & ~aw_done_bad;

  assign wq_empty = (wq_wr == wq_rd);
  assign wq_full  = (wq_wr[IDX_W-1:0] == wq_rd[IDX_W-1:0]) & (wq_wr[IDX_W] != wq_rd[IDX_W]);
  assign w_go     = ARESETn & bus.w_valid & bus.w_ready & ~wq_empty;
  assign wq_push  = aw_go;
  assign wq_pop   = w_go & bus.w_last;

  assign bus.ar_issue      = ar_go;
  assign bus.aw_issue      = aw_go;
  assign bus.w_pop         = w_go;
  assign bus.w_route_valid = ARESETn & ~wq_empty;
  assign bus.w_dest        = (ARESETn & ~wq_empty) ? wq_mem[wq_rd[IDX_W-1:0]] : '0;
  assign bus.err           = ARESETn & err_q;

  // Read-side per-ID counters and destination table.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int i = 0; i < int'(N_ID); i++) begin
        ar_cnt[i] <= '0;
        ar_tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_ID); i++) begin
        if (ar_go && (bus.ar_id == ID_WIDTH'(i)) &&
            !(ar_done_ok && (bus.r_done_id == ID_WIDTH'(i)))) begin
          ar_cnt[i] <= ar_cnt[i] + CNT_ONE;
        end else if (ar_done_ok && (bus.r_done_id == ID_WIDTH'(i)) &&
                     !(ar_go && (bus.ar_id == ID_WIDTH'(i)))) begin
          ar_cnt[i] <= ar_cnt[i] - CNT_ONE;
        end
        if (ar_go && (bus.ar_id == ID_WIDTH'(i))) begin
          ar_tbl[i] <= bus.ar_dest;
        end
      end
    end
  end

  // Write-side per-ID counters and destination table.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      for (int i = 0; i < int'(N_ID); i++) begin
        aw_cnt[i] <= '0;
        aw_tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N_ID); i++) begin
        if (aw_go && (bus.aw_id == ID_WIDTH'(i)) &&
            !(aw_done_ok && (bus.b_done_id == ID_WIDTH'(i)))) begin
          aw_cnt[i] <= aw_cnt[i] + CNT_ONE;
        end else if (aw_done_ok && (bus.b_done_id == ID_WIDTH'(i)) &&
                     !(aw_go && (bus.aw_id == ID_WIDTH'(i)))) begin
          aw_cnt[i] <= aw_cnt[i] - CNT_ONE;
        end
        if (aw_go && (bus.aw_id == ID_WIDTH'(i))) begin
          aw_tbl[i] <= bus.aw_dest;
        end
      end
    end
  end

  // AW destination queue; the head advances only on the last W beat.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wq_wr <= '0;
      wq_rd <= '0;
      for (int i = 0; i < int'(WQ_DEPTH); i++) begin
        wq_mem[i] <= '0;
      end
    end else begin
      if (wq_push) begin
        wq_mem[wq_wr[IDX_W-1:0]] <= bus.aw_dest;
        wq_wr                    <= wq_wr + PTR_ONE;
      end
      if (wq_pop) begin
        wq_rd <= wq_rd + PTR_ONE;
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      err_q <= 1'b0;
    end else if (ar_done_bad || aw_done_bad) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_xbar_id_tracker.sv
// Scenario bench for xbar_id_tracker; W routing checked against a queue of expected destinations.
module tb_xbar_id_tracker;

  localparam int unsigned IDW  = 4;
  localparam int unsigned DW   = 1;
  localparam int unsigned MAXO = 4;
  localparam int unsigned WQD  = 4;

  logic ACLK;
  logic ARESETn;

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0] sb [$];

  xbar_id_tracker_if #(.ID_WIDTH(IDW), .DEST_WIDTH(DW)) bus ();

  xbar_id_tracker #(
    .ID_WIDTH       (IDW),
    .slaves         (2),
    .MAX_OUTSTANDING(MAXO),
    .WQ_DEPTH       (WQD)
  ) dut (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .bus    (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "time limit expired");
  end

  task automatic idle();
    bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_dest = '0; bus.ar_ready = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_dest = '0; bus.aw_ready = 1'b0;
    bus.r_done = 1'b0; bus.r_done_id = '0; bus.b_done = 1'b0; bus.b_done_id = '0;
    bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.w_ready = 1'b0;
  endtask

  task automatic r_drain(input logic [IDW-1:0] id, input int n);
    for (int k = 0; k < n; k++) begin
      bus.r_done = 1'b1; bus.r_done_id = id;
      @(negedge ACLK);
    end
    bus.r_done = 1'b0;
  endtask

  task automatic b_drain(input logic [IDW-1:0] id, input int n);
    for (int k = 0; k < n; k++) begin
      bus.b_done = 1'b1; bus.b_done_id = id;
      @(negedge ACLK);
    end
    bus.b_done = 1'b0;
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    bus.ar_valid = 1'b1; bus.ar_ready = 1'b1; bus.ar_id = 4'd3;
    bus.aw_valid = 1'b1; bus.aw_ready = 1'b1; bus.aw_id = 4'd1;
    bus.w_valid = 1'b1; bus.w_ready = 1'b1; bus.w_last = 1'b1;
    #1;
    vectors++; if (bus.ar_issue !== 1'b0) begin miscompares++; $display("FAIL reset_ar_issue: got %b expected 0", bus.ar_issue); end
    vectors++; if (bus.aw_issue !== 1'b0) begin miscompares++; $display("FAIL reset_aw_issue: got %b expected 0", bus.aw_issue); end
    vectors++; if (bus.w_pop !== 1'b0) begin miscompares++; $display("FAIL reset_w_pop: got %b expected 0", bus.w_pop); end
    vectors++; if (bus.w_route_valid !== 1'b0) begin miscompares++; $display("FAIL reset_route_valid: got %b expected 0", bus.w_route_valid); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    @(negedge ACLK);
    @(negedge ACLK);
    idle();
    ARESETn = 1'b1;
    #1;
    vectors++; if (bus.w_route_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_route_valid: got %b expected 0", bus.w_route_valid); end
    vectors++; if (bus.w_dest !== 1'b0) begin miscompares++; $display("FAIL post_reset_w_dest: got %b expected 0", bus.w_dest); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL post_reset_err: got %b expected 0", bus.err); end
    @(negedge ACLK);
  endtask

  task automatic test_same_id_pipeline();
    idle();
    bus.ar_valid = 1'b1; bus.ar_ready = 1'b1; bus.ar_id = 4'd3; bus.ar_dest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL pipe_issue_%0d: got %b expected 1", i, bus.ar_issue); end
      @(negedge ACLK);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (bus.ar_issue !== 1'b0) begin miscompares++; $display("FAIL pipe_cap_block_%0d: got %b expected 0", i, bus.ar_issue); end
      @(negedge ACLK);
    end
    r_drain(4'd3, 1);
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL pipe_after_done: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_valid = 1'b0;
    r_drain(4'd3, 4);
    bus.ar_valid = 1'b1; bus.ar_dest = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL pipe_drained_new_dest: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_valid = 1'b0;
    r_drain(4'd3, 1);
    #1;
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL pipe_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_order_block();
    idle();
    bus.ar_valid = 1'b1; bus.ar_ready = 1'b1; bus.ar_id = 4'd5; bus.ar_dest = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL order_first: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_dest = 1'b1;
    #1;
    vectors++; if (bus.ar_issue !== 1'b0) begin miscompares++; $display("FAIL order_blocked: got %b expected 0", bus.ar_issue); end
    @(negedge ACLK);
    bus.r_done = 1'b1; bus.r_done_id = 4'd5;
    #1;
    vectors++; if (bus.ar_issue !== 1'b0) begin miscompares++; $display("FAIL order_done_cycle: got %b expected 0", bus.ar_issue); end
    @(negedge ACLK);
    bus.r_done = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL order_after_done: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_dest = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b0) begin miscompares++; $display("FAIL order_dest_updated: got %b expected 0", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_dest = 1'b1;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL order_same_dest: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_valid = 1'b0;
    r_drain(4'd5, 2);
  endtask

  task automatic test_issue_done();
    idle();
    bus.ar_valid = 1'b1; bus.ar_ready = 1'b1; bus.ar_id = 4'd2; bus.ar_dest = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL id2_fill_%0d: got %b expected 1", i, bus.ar_issue); end
      @(negedge ACLK);
    end
    bus.ar_id = 4'd7; bus.ar_dest = 1'b1;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL id7_fill: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_id = 4'd2; bus.ar_dest = 1'b0; bus.r_done = 1'b1; bus.r_done_id = 4'd2;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL same_id_issue_done: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.r_done_id = 4'd7;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL diff_id_issue_done: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.r_done = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL id2_to_cap: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    #1;
    vectors++; if (bus.ar_issue !== 1'b0) begin miscompares++; $display("FAIL id2_at_cap: got %b expected 0", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_id = 4'd7; bus.ar_dest = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL id7_zero: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    bus.ar_valid = 1'b0;
    r_drain(4'd2, 4);
    r_drain(4'd7, 1);
    #1;
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL issue_done_err: got %b expected 0", bus.err); end
  endtask

  task automatic test_write_queue();
    logic [DW-1:0] dests [4];
    int            bursts [5];
    int            occ;
    logic          aw_pend;
    logic          exp_aw;
    logic [DW-1:0] exp_dest;
    dests  = '{1'b1, 1'b0, 1'b1, 1'b1};
    bursts = '{2, 1, 3, 1, 1};
    idle();
    bus.aw_valid = 1'b1; bus.aw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.aw_id = IDW'(i); bus.aw_dest = dests[i];
      sb.push_back(dests[i]);
      #1;
      vectors++; if (bus.aw_issue !== 1'b1) begin miscompares++; $display("FAIL wq_fill_%0d: got %b expected 1", i, bus.aw_issue); end
      @(negedge ACLK);
    end
    bus.aw_id = 4'd4; bus.aw_dest = 1'b0;
    #1;
    vectors++; if (bus.aw_issue !== 1'b0) begin miscompares++; $display("FAIL wq_full_block: got %b expected 0", bus.aw_issue); end
    vectors++; if (bus.w_route_valid !== 1'b1) begin miscompares++; $display("FAIL wq_route_valid: got %b expected 1", bus.w_route_valid); end
    @(negedge ACLK);
    occ = 4; aw_pend = 1'b1;
    bus.w_valid = 1'b1; bus.w_ready = 1'b1;
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < bursts[b]; k++) begin
        bus.w_last = (k == bursts[b] - 1);
        #1;
        exp_aw = aw_pend && (occ < int'(WQD));
        vectors++; if (bus.aw_issue !== exp_aw) begin miscompares++; $display("FAIL wq_aw_b%0d_k%0d: got %b expected %b", b, k, bus.aw_issue, exp_aw); end
        vectors++; if (bus.w_pop !== 1'b1) begin miscompares++; $display("FAIL wq_pop_b%0d_k%0d: got %b expected 1", b, k, bus.w_pop); end
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL wq_dest_b%0d_k%0d: got %b expected no pending route", b, k, bus.w_dest);
        end else begin
          exp_dest = sb[0];
          vectors++; if (bus.w_dest !== exp_dest) begin miscompares++; $display("FAIL wq_dest_b%0d_k%0d: got %b expected %b", b, k, bus.w_dest, exp_dest); end
        end
        if (exp_aw) begin
          sb.push_back(1'b0);
          aw_pend = 1'b0;
          occ++;
        end
        if (bus.w_last && sb.size() != 0) begin
          void'(sb.pop_front());
          occ--;
        end
        @(negedge ACLK);
        if (!aw_pend) bus.aw_valid = 1'b0;
      end
    end
    bus.w_last = 1'b1;
    #1;
    vectors++; if (bus.w_pop !== 1'b0) begin miscompares++; $display("FAIL wq_empty_no_pop: got %b expected 0", bus.w_pop); end
    vectors++; if (bus.w_route_valid !== 1'b0) begin miscompares++; $display("FAIL wq_empty_route: got %b expected 0", bus.w_route_valid); end
    @(negedge ACLK);
    idle();
    for (int i = 0; i < 5; i++) b_drain(IDW'(i), 1);
  endtask

  task automatic test_empty_latency();
    logic [DW-1:0] exp_dest;
    idle();
    bus.w_valid = 1'b1; bus.w_ready = 1'b1; bus.w_last = 1'b1;
    bus.aw_valid = 1'b1; bus.aw_ready = 1'b1; bus.aw_id = 4'd6; bus.aw_dest = 1'b1;
    sb.push_back(1'b1);
    #1;
    vectors++; if (bus.aw_issue !== 1'b1) begin miscompares++; $display("FAIL lat_aw_issue: got %b expected 1", bus.aw_issue); end
    vectors++; if (bus.w_pop !== 1'b0) begin miscompares++; $display("FAIL lat_no_bypass: got %b expected 0", bus.w_pop); end
    vectors++; if (bus.w_route_valid !== 1'b0) begin miscompares++; $display("FAIL lat_route_t0: got %b expected 0", bus.w_route_valid); end
    @(negedge ACLK);
    bus.aw_valid = 1'b0;
    #1;
    exp_dest = sb.pop_front();
    vectors++; if (bus.w_pop !== 1'b1) begin miscompares++; $display("FAIL lat_pop_t1: got %b expected 1", bus.w_pop); end
    vectors++; if (bus.w_dest !== exp_dest) begin miscompares++; $display("FAIL lat_dest_t1: got %b expected %b", bus.w_dest, exp_dest); end
    @(negedge ACLK);
    #1;
    vectors++; if (bus.w_pop !== 1'b0) begin miscompares++; $display("FAIL lat_drained: got %b expected 0", bus.w_pop); end
    @(negedge ACLK);
    idle();
    b_drain(4'd6, 1);
  endtask

  task automatic test_err_and_reset();
    idle();
    #1;
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_clean: got %b expected 0", bus.err); end
    bus.b_done = 1'b1; bus.b_done_id = 4'd9;
    #1;
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL err_registered: got %b expected 0", bus.err); end
    @(negedge ACLK);
    bus.b_done = 1'b0;
    #1;
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL err_set: got %b expected 1", bus.err); end
    @(negedge ACLK);
    bus.aw_valid = 1'b1; bus.aw_ready = 1'b1; bus.aw_id = 4'd9; bus.aw_dest = 1'b1;
    #1;
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL err_sticky: got %b expected 1", bus.err); end
    vectors++; if (bus.aw_issue !== 1'b1) begin miscompares++; $display("FAIL err_cnt_held: got %b expected 1", bus.aw_issue); end
    @(negedge ACLK);
    bus.aw_valid = 1'b0;
    bus.ar_valid = 1'b1; bus.ar_ready = 1'b1; bus.ar_id = 4'd1; bus.ar_dest = 1'b0;
    bus.w_valid = 1'b1; bus.w_ready = 1'b1; bus.w_last = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL mid_ar_issue: got %b expected 1", bus.ar_issue); end
    @(negedge ACLK);
    ARESETn = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ar_issue: got %b expected 0", bus.ar_issue); end
    vectors++; if (bus.w_pop !== 1'b0) begin miscompares++; $display("FAIL mid_rst_w_pop: got %b expected 0", bus.w_pop); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err: got %b expected 0", bus.err); end
    @(negedge ACLK);
    ARESETn = 1'b1;
    sb.delete();
    bus.ar_dest = 1'b1;
    bus.aw_valid = 1'b1; bus.aw_id = 4'd9; bus.aw_dest = 1'b0;
    #1;
    vectors++; if (bus.ar_issue !== 1'b1) begin miscompares++; $display("FAIL rst_ar_cnt_cleared: got %b expected 1", bus.ar_issue); end
    vectors++; if (bus.aw_issue !== 1'b1) begin miscompares++; $display("FAIL rst_aw_cnt_cleared: got %b expected 1", bus.aw_issue); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL rst_err_cleared: got %b expected 0", bus.err); end
    vectors++; if (bus.w_route_valid !== 1'b0) begin miscompares++; $display("FAIL rst_route_cleared: got %b expected 0", bus.w_route_valid); end
    vectors++; if (bus.w_pop !== 1'b0) begin miscompares++; $display("FAIL rst_no_pop: got %b expected 0", bus.w_pop); end
    @(negedge ACLK);
    idle();
  endtask

  initial begin
    idle();
    ARESETn = 1'b0;
    test_reset();
    test_same_id_pipeline();
    @(negedge ACLK);
    test_order_block();
    test_issue_done();
    @(negedge ACLK);
    test_write_queue();
    test_empty_latency();
    test_err_and_reset();
    @(negedge ACLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
